// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

    // Default operand width (also the number of add/shift iterations).
    localparam int MULT_N = 4;

    // Control FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_e;

endpackage

// File: rtl/shift_add_ctrl_iter_counter.sv
// Iteration counter for the multiplier control FSM: synchronous clear,
// increment enable and a flag that marks the last iteration (count == N-1).
module iter_counter
    import mult_pkg::*;
#(
    parameter int N = MULT_N
)
(
    input  logic clk,
    input  logic rst,
    input  logic cnt_clr,
    input  logic cnt_inc,
    output logic cnt_last
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] count_r;

    // Iteration count: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (cnt_clr) begin
            count_r <= {CW{1'b0}};
        end else if (cnt_inc) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign cnt_last = (count_r == CW'(N - 1));

endmodule

// File: rtl/shift_add_ctrl.sv
// Control FSM for the sequential shift-and-add multiplier. Drives the
// datapath strobes from a start/done handshake and the multiplier LSB.
module shift_add_ctrl
    import mult_pkg::*;
#(
    parameter int N = MULT_N
)
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic b_lsb,
    output logic load_ab,
    output logic clr_p,
    output logic add_en,
    output logic load_p,
    output logic shift_en,
    output logic busy,
    output logic done
);

    mult_state_e state_r;
    mult_state_e state_nxt_s;

    logic cnt_clr_s;
    logic cnt_inc_s;
    logic cnt_last_s;

    iter_counter #(
        .N (N)
    ) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_clr  (cnt_clr_s),
        .cnt_inc  (cnt_inc_s),
        .cnt_last (cnt_last_s)
    );

    // State register; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and Moore output decode; only add_en/load_p in ADD follow b_lsb.
    always_comb begin
        state_nxt_s = state_r;
        load_ab     = 1'b0;
        clr_p       = 1'b0;
        add_en      = 1'b0;
        load_p      = 1'b0;
        shift_en    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                load_ab     = 1'b1;
                clr_p       = 1'b1;
                busy        = 1'b1;
                cnt_clr_s   = 1'b1;
                state_nxt_s = ADD;
            end
            ADD: begin
                busy        = 1'b1;
                add_en      = b_lsb;
                load_p      = b_lsb;
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                shift_en  = 1'b1;
                busy      = 1'b1;
                cnt_inc_s = 1'b1;
                if (cnt_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                done        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Scoreboard bench for shift_add_ctrl at N=4, N=2 and N=8. A cycle-age
// reference model pushes expected strobes each cycle; a monitor pops and
// compares. A behavioural datapath closes the loop through b_lsb and the
// final product is checked against plain multiplication.
module tb_shift_add_ctrl;

    typedef struct {
        logic [6:0] o;
        bit         cp;
        int         prod;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] outs [3];
    logic       blsb [3];
    int         op_a;
    int         op_b;

    int   dp_a [3];
    int   dp_b [3];
    int   dp_p [3];
    int   age  [3];
    int   exp_prod [3];
    exp_t sb [3][$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int nv(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic int msk(input int i);
        return (1 << nv(i)) - 1;
    endfunction

    // Expected {load_ab,clr_p,add_en,load_p,shift_en,busy,done} for a cycle
    // 'age' cycles after the edge that accepted start (0 = idle).
    function automatic logic [6:0] exp_out(input int a, input int n, input logic lsb);
        if (a == 1) return 7'b1100010;
        if (a >= 2 && a <= 2 * n + 1) begin
            if (a % 2 == 0) return {2'b00, lsb, lsb, 3'b010};
            return 7'b0000110;
        end
        if (a == 2 * n + 2) return 7'b0000001;
        return 7'b0000000;
    endfunction

    shift_add_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .b_lsb(blsb[0]),
        .load_ab(outs[0][6]), .clr_p(outs[0][5]), .add_en(outs[0][4]),
        .load_p(outs[0][3]), .shift_en(outs[0][2]), .busy(outs[0][1]),
        .done(outs[0][0])
    );

    shift_add_ctrl #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .b_lsb(blsb[1]),
        .load_ab(outs[1][6]), .clr_p(outs[1][5]), .add_en(outs[1][4]),
        .load_p(outs[1][3]), .shift_en(outs[1][2]), .busy(outs[1][1]),
        .done(outs[1][0])
    );

    shift_add_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .b_lsb(blsb[2]),
        .load_ab(outs[2][6]), .clr_p(outs[2][5]), .add_en(outs[2][4]),
        .load_p(outs[2][3]), .shift_en(outs[2][2]), .busy(outs[2][1]),
        .done(outs[2][0])
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier LSB fed back from the behavioural datapath.
    always_comb begin
        for (int i = 0; i < 3; i++) blsb[i] = dp_b[i][0];
    end

    // Behavioural datapath driven by the controller strobes.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                dp_a[i] <= 0;
                dp_b[i] <= 0;
                dp_p[i] <= 0;
            end else begin
                if (outs[i][6]) begin
                    dp_a[i] <= op_a & msk(i);
                    dp_b[i] <= op_b & msk(i);
                end
                if (outs[i][5]) begin
                    dp_p[i] <= 0;
                end else if (outs[i][3]) begin
                    dp_p[i] <= outs[i][4] ? dp_p[i] + dp_a[i] : dp_p[i];
                end else if (outs[i][2]) begin
                    dp_p[i] <= dp_p[i] >> 1;
                    dp_b[i] <= (dp_b[i] >> 1) | ((dp_p[i] & 1) << (nv(i) - 1));
                end
            end
        end
    end

    // Reference model: advance operation age on each edge, push expectations.
    initial begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            age[i] = 0;
            exp_prod[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst)                         age[i] = 0;
                else if (age[i] == 0)            age[i] = start ? 1 : 0;
                else if (age[i] == 2 * nv(i) + 2) age[i] = 0;
                else                             age[i] = age[i] + 1;
            end
            #4;
            for (int i = 0; i < 3; i++) begin
                if (rst) age[i] = 0;
                if (age[i] == 1) exp_prod[i] = (op_a & msk(i)) * (op_b & msk(i));
                e.o    = exp_out(age[i], nv(i), blsb[i]);
                e.cp   = (age[i] == 2 * nv(i) + 2);
                e.prod = exp_prod[i];
                sb[i].push_back(e);
            end
        end
    end

    // Monitor: pop expectations and compare against DUT outputs.
    initial begin
        exp_t e;
        int   prod;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (sb[i].size() == 0) begin
                    $display("FAIL sb_empty[N=%0d] t=%0t got no expectation want one", nv(i), $time);
                end else begin
                    e = sb[i].pop_front();
                    if (outs[i] === e.o) n_pass++;
                    else $display("FAIL outs[N=%0d] t=%0t got %b want %b", nv(i), $time, outs[i], e.o);
                    if (e.cp) begin
                        n_chk++;
                        prod = (dp_p[i] << nv(i)) | dp_b[i];
                        if (prod == e.prod) n_pass++;
                        else $display("FAIL product[N=%0d] t=%0t got %0d want %0d", nv(i), $time, prod, e.prod);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Stimulus.
    initial begin
        rst = 1'b1; start = 1'b0; op_a = 0; op_b = 0;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        // A=7, B=10 (LSB pattern 0,1,0,1 for N=4)
        op_a = 7; op_b = 10;
        pulse_start(); cyc(24);
        // b_lsb constantly 1 for N=4
        op_a = 5; op_b = 15;
        pulse_start(); cyc(24);
        // start pulses in cycles 3 and 10 are ignored by the N=4 instance
        op_a = 9; op_b = 6;
        pulse_start(); cyc(2);
        pulse_start(); cyc(6);
        pulse_start(); cyc(24);
        // reset asserted in cycle 5, then a fresh operation
        op_a = 11; op_b = 13;
        pulse_start(); cyc(4);
        rst = 1'b1; cyc(2);
        rst = 1'b0; cyc(3);
        pulse_start(); cyc(24);
        // start held high for 30 cycles
        op_a = 3; op_b = 14;
        start = 1'b1; cyc(30);
        start = 1'b0; cyc(24);
        // randomized operands, start and occasional reset
        for (int t = 0; t < 400; t++) begin
            op_a  = int'($urandom_range(0, 255));
            op_b  = int'($urandom_range(0, 255));
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        start = 1'b0; rst = 1'b0;
        cyc(30);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_add_ctrl.md
# shift_add_ctrl

Control FSM for the sequential shift-and-add multiplier. It sequences the multiplier datapath: the operand A and B registers, the product accumulator, the adder and the shifter. It drives their load, clear, add and shift strobes from a start/done handshake and the current multiplier LSB. It holds no operand data itself; all arithmetic stays in the datapath.

## Interface
Parameters:
- N, 4, operand width in bits; also the number of add/shift iterations (N ≥ 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- b_lsb  in  1  bit 0 of the datapath B (multiplier) register.
- load_ab  out  1  load operand registers A and B from the inputs.
- clr_p  out  1  clear the product accumulator.
- add_en  out  1  select adder output into the accumulator.
- load_p  out  1  accumulator load enable.
- shift_en  out  1  shift the accumulator/B pair right by one.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- Iteration counter width: $clog2(N+1).
- Outputs are Moore outputs, decoded from the registered state only. The single exception is add_en/load_p in ADD, which follow b_lsb.
- IDLE
  - All outputs are 0.
  - start=1 → LOAD.
- LOAD
  - load_ab=1, clr_p=1, busy=1.
  - Counter is cleared to 0.
  - → ADD.
- ADD
  - busy=1.
  - add_en=load_p=b_lsb.
  - → SHIFT.
- SHIFT
  - shift_en=1, busy=1.
  - Counter increments.
  - If the counter before the increment equals N-1 → DONE; otherwise → ADD.
- DONE
  - done=1, busy=0.
  - → IDLE unconditionally.
- start is ignored in LOAD, ADD, SHIFT and DONE. No request is queued.
- Reset value: state=IDLE, counter=0, every output 0.
- Reset asserted mid-operation: the FSM goes to IDLE immediately (asynchronously). No done is produced for the aborted operation.
- Strobes are mutually exclusive per cycle, with two allowed pairs:
  - load_ab with clr_p;
  - add_en with load_p.
- shift_en is never asserted together with load_p.

## Timing
- The edge that samples start=1 in IDLE is edge 0. The cycles that follow are:
  - cycle 1: LOAD;
  - cycles 2k and 2k+1 (k=1..N): ADD and SHIFT of iteration k;
  - cycle 2N+2: DONE;
  - cycle 2N+3: IDLE.
- Total latency from start to done is 2N+2 cycles; for N=4, done is high in cycle 10.
- busy is high in cycles 1 through 2N+1.
- If start is held high continuously, the next LOAD occurs in cycle 2N+4. The minimum spacing between operations is 2N+3 cycles.
- b_lsb must be valid in every ADD cycle. It reflects B after the previous SHIFT, which the datapath guarantees through its registered shifter.
- No combinational path from start to any output.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, LOAD, ADD, SHIFT, DONE);
  - the default width constant MULT_N = 4.
- One natural sub-module: iter_counter. It provides a synchronous clear, an increment enable, and a terminal flag at N-1. It uses the same asynchronous reset.

## Test plan
- Reset during operation: pulse start, then assert rst in cycle 5 (mid-iteration 2).
  - All outputs must read 0 in the same cycle.
  - done is never seen.
  - After reset release, a new start gives done at cycle 10.
- Basic timing, N=4: start pulse with b_lsb=1 constantly.
  - load_ab and clr_p in cycle 1.
  - load_p in cycles 2, 4, 6 and 8; shift_en in cycles 3, 5, 7 and 9.
  - done in cycle 10 only.
  - busy high in cycles 1–9.
- LSB pattern: multiplier pattern 1010₂, so b_lsb is 0, 1, 0, 1 across iterations 1–4.
  - load_p high only in cycles 4 and 8.
  - A datapath model with A=7 and B=10 must yield 70.
- Start ignored while busy: start pulses in cycles 3 and 10.
  - No second LOAD occurs.
  - Exactly one done, in cycle 10.
- Back-to-back: start held high for 30 cycles.
  - LOAD occurs in cycles 1 and 12.
  - done occurs in cycles 10 and 21.
- Width sweep: N=2 and N=8.
  - done occurs in cycles 6 and 18 respectively.
  - The shift_en count per operation equals N.
